// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch, data and memory-port signals shared by
//               mem_port_arbiter and its environment.
//               slave  : arbiter side (takes requests, drives the memory port)
//               master : environment side (core stages plus memory model)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch stage
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   // memory stage
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   // unified memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   // pipeline stalls
   logic              stall_f;
   logic              stall_m;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, dm_rdata, dm_valid,
      output mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, dm_rdata, dm_valid,
      input  mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency memory port between the fetch and
//               memory stages. One access at a time, data has priority, read
//               data returned with a one-cycle valid pulse, stalls derived
//               from request and valid.
//               Optional build macro MEM_PORT_ARBITER_STARVE_GUARD_EN adds a
//               starvation counter that forces a fetch grant after STARVE_MAX
//               consecutive data grants made while fetch was waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Counter is loaded with MEM_LAT-1 at issue and reaches 0 in the data cycle.
   localparam int             LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_t           state;
   state_t           state_next;
   logic [LAT_W-1:0] lat_cnt;
   logic             busy;
   logic             lat_done;
   logic             grant_i;
   logic             grant_d;
   logic             force_fetch;

   assign busy     = (state == BUSY_I) || (state == BUSY_D);
   assign lat_done = busy && (lat_cnt == '0);

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
   localparam int              SC_W       = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

   logic [SC_W-1:0] starve_cnt;

   assign force_fetch = bus.if_req && (starve_cnt == STARVE_LIM);

   // Count data grants that bypassed a waiting fetch; any fetch grant clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && bus.if_req && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   // Strict data priority: the term is constant-false for any legal STARVE_MAX.
   assign force_fetch = bus.if_req && (STARVE_MAX < 1);
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Arbitration and next-state selection.
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.dm_req && !force_fetch) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (bus.if_req) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (lat_done) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latency counter: loaded on issue, counts down while busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt <= '0;
      end else if (grant_i || grant_d) begin
         lat_cnt <= LAT_LOAD;
      end else if (busy && (lat_cnt != '0)) begin
         lat_cnt <= lat_cnt - 1'b1;
      end
   end

   // Memory request registers, read-data capture and valid pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
         bus.if_rdata  <= {DATA_W{1'b0}};
         bus.dm_rdata  <= {DATA_W{1'b0}};
         bus.if_valid  <= 1'b0;
         bus.dm_valid  <= 1'b0;
      end else begin
         bus.mem_req  <= 1'b0;
         bus.if_valid <= 1'b0;
         bus.dm_valid <= 1'b0;
         if (grant_d) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
         end else if (grant_i) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= {DATA_W{1'b0}};
         end
         if (lat_done && (state == BUSY_I)) begin
            bus.if_rdata <= bus.mem_rdata;
            bus.if_valid <= 1'b1;
         end
         if (lat_done && (state == BUSY_D)) begin
            // A store completes without disturbing the last load result.
            if (!bus.mem_we) begin
               bus.dm_rdata <= bus.mem_rdata;
            end
            bus.dm_valid <= 1'b1;
         end
      end
   end

   assign bus.stall_f = bus.if_req && !bus.if_valid;
   assign bus.stall_m = bus.dm_req && !bus.dm_valid;

endmodule
`default_nettype wire
